dpram_port_arbiter: RTL and testbench

//  Shares both ports of one true_dpram instance (SYNC_READ=1) between N_REQ requesters.

---
 rtl/dpram_port_arbiter_pkg.sv | 19 +
 rtl/dpram_port_arbiter_rr_pick.sv | 33 +++
 rtl/dpram_port_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_dpram_port_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_port_arbiter_pkg.sv
// dpram_port_arbiter_pkg.sv
// Shared states and helpers for the dual-port RAM arbiter.
package dpram_port_arbiter_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

  localparam int RSP_LAT = 1;

  function automatic int wrap_idx(
    input int v,
    input int n
  );
    return v % n;
  endfunction

endpackage

// File: rtl/dpram_port_arbiter_rr_pick.sv
// rr_pick.sv
// Round-robin first-found picker over a valid vector.
module rr_pick
  import dpram_port_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   valid,
  input  logic [IDW-1:0] start,
  output logic [N-1:0]   onehot,
  output logic [IDW-1:0] idx,
  output logic           found
);

  logic [IDW-1:0] cand;

  // first valid index at or after start, wrapping modulo N
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDW'(wrap_idx(int'(start) + k, N));
      if (!found && valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    onehot = found ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter.sv
// Shares both ports of a sync-read true DPRAM among N_REQ requesters.
module dpram_port_arbiter
  import dpram_port_arbiter_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 32,
  parameter  int N_REQ = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  output logic                   init_busy,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ-1:0]       req_we,
  input  logic [N_REQ*AW-1:0]    req_addr,
  input  logic [N_REQ*WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [N_REQ*WIDTH-1:0] rsp_rdata,
  output logic [WIDTH-1:0]       ram0_din,
  output logic                   ram0_we,
  output logic [AW-1:0]          ram0_addr,
  output logic                   ram0_en,
  input  logic [WIDTH-1:0]       ram0_dout,
  output logic [WIDTH-1:0]       ram1_din,
  output logic                   ram1_we,
  output logic [AW-1:0]          ram1_addr,
  output logic                   ram1_en,
  input  logic [WIDTH-1:0]       ram1_dout
);

  arb_state_e state_q, state_d;
  logic [AW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0] rr_q, rr_d;

  logic [RSP_LAT-1:0] rd0_q, rd1_q;
  logic [IDW-1:0]     id0_q, id1_q;

  logic [N_REQ-1:0] oh_a, oh_b, valid_b;
  logic [IDW-1:0]   id_a, id_b, start_b;
  logic             fnd_a, fnd_b;

  logic [AW-1:0]    addr_a, addr_b;
  logic [WIDTH-1:0] wd_a, wd_b;
  logic             we_a, we_b;
  logic             clash, gnt_a, gnt_b;
  logic             run, sweep;

  assign run       = (state_q == ST_RUN);
  assign sweep     = (state_q == ST_INIT) && rst_n;
  assign init_busy = (state_q == ST_INIT);

  rr_pick #(
    .N   (N_REQ),
    .IDW (IDW)
  ) u_pick_a (
    .valid  (req_valid),
    .start  (rr_q),
    .onehot (oh_a),
    .idx    (id_a),
    .found  (fnd_a)
  );

  assign valid_b = req_valid & ~oh_a;
  assign start_b = IDW'(wrap_idx(int'(id_a) + 1, N_REQ));

  rr_pick #(
    .N   (N_REQ),
    .IDW (IDW)
  ) u_pick_b (
    .valid  (valid_b),
    .start  (start_b),
    .onehot (oh_b),
    .idx    (id_b),
    .found  (fnd_b)
  );

  assign addr_a = req_addr[id_a*AW +: AW];
  assign addr_b = req_addr[id_b*AW +: AW];
  assign wd_a   = req_wdata[id_a*WIDTH +: WIDTH];
  assign wd_b   = req_wdata[id_b*WIDTH +: WIDTH];
  assign we_a   = req_we[id_a];
  assign we_b   = req_we[id_b];

  // grant A always; B only when it cannot collide with A on a write
  always_comb begin
    clash     = (addr_a == addr_b) && (we_a || we_b);
    gnt_a     = run && fnd_a;
    gnt_b     = run && fnd_a && fnd_b && !clash;
    req_ready = '0;
    if (gnt_a) req_ready = req_ready | oh_a;
    if (gnt_b) req_ready = req_ready | oh_b;
  end

  // RAM port drive: zero sweep in INIT, granted requests in RUN
  always_comb begin
    ram0_en   = 1'b0;
    ram0_we   = 1'b0;
    ram0_addr = '0;
    ram0_din  = '0;
    ram1_en   = 1'b0;
    ram1_we   = 1'b0;
    ram1_addr = '0;
    ram1_din  = '0;
    if (sweep) begin
      ram0_en   = 1'b1;
      ram0_we   = 1'b1;
      ram0_addr = ptr_q;
      ram1_en   = 1'b1;
      ram1_we   = 1'b1;
      ram1_addr = ptr_q + AW'(1);
    end else begin
      if (gnt_a) begin
        ram0_en   = 1'b1;
        ram0_we   = we_a;
        ram0_addr = addr_a;
        ram0_din  = wd_a;
      end
      if (gnt_b) begin
        ram1_en   = 1'b1;
        ram1_we   = we_b;
        ram1_addr = addr_b;
        ram1_din  = wd_b;
      end
    end
  end

  // next state, sweep pointer and round-robin pointer
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rr_d    = rr_q;
    unique case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + AW'(2);
        if (clear) begin
          ptr_d = '0;
        end else if (ptr_q == AW'(DEPTH - 2)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clear) begin
          state_d = ST_INIT;
          ptr_d   = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
    if (gnt_b) begin
      rr_d = IDW'(wrap_idx(int'(id_b) + 1, N_REQ));
    end else if (gnt_a) begin
      rr_d = IDW'(wrap_idx(int'(id_a) + 1, N_REQ));
    end
  end

  // state registers and per-port read tags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      rr_q    <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      id0_q   <= '0;
      id1_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rr_q    <= rr_d;
      rd0_q   <= RSP_LAT'(gnt_a && !we_a);
      rd1_q   <= RSP_LAT'(gnt_b && !we_b);
      id0_q   <= id_a;
      id1_q   <= id_b;
    end
  end

  // route registered read data back to the tagged requester
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (rd0_q[RSP_LAT-1]) begin
      rsp_valid[id0_q]                 = 1'b1;
      rsp_rdata[id0_q*WIDTH +: WIDTH] = ram0_dout;
    end
    if (rd1_q[RSP_LAT-1]) begin
      rsp_valid[id1_q]                 = 1'b1;
      rsp_rdata[id1_q*WIDTH +: WIDTH] = ram1_dout;
    end
  end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb_dpram_port_arbiter.sv
// Directed and random checks of the DPRAM arbiter against a bench model.
module tb_dpram_port_arbiter;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int N  = 4;
  localparam int AW = 5;
  localparam int PT = 2 + AW + W;

  logic           clk;
  logic           rst_n;
  logic           clear;
  logic           init_busy;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*W-1:0] req_wdata;
  logic [N-1:0]   rsp_valid;
  logic [N*W-1:0] rsp_rdata;
  logic [W-1:0]   ram0_din, ram1_din;
  logic           ram0_we, ram1_we;
  logic [AW-1:0]  ram0_addr, ram1_addr;
  logic           ram0_en, ram1_en;
  logic [W-1:0]   ram0_dout, ram1_dout;

  int n_tests = 0;
  int n_fail  = 0;

  dpram_port_arbiter #(
    .WIDTH (W),
    .DEPTH (D),
    .N_REQ (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .init_busy (init_busy),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ram0_din  (ram0_din),
    .ram0_we   (ram0_we),
    .ram0_addr (ram0_addr),
    .ram0_en   (ram0_en),
    .ram0_dout (ram0_dout),
    .ram1_din  (ram1_din),
    .ram1_we   (ram1_we),
    .ram1_addr (ram1_addr),
    .ram1_en   (ram1_en),
    .ram1_dout (ram1_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sync-read true dual-port RAM
  logic [W-1:0] ram [D];
  initial begin
    for (int k = 0; k < D; k++) ram[k] = $urandom;
    ram0_dout = '0;
    ram1_dout = '0;
  end
  always @(posedge clk) begin
    if (ram0_en) begin
      if (ram0_we) ram[ram0_addr] <= ram0_din;
      else         ram0_dout <= ram[ram0_addr];
    end
    if (ram1_en) begin
      if (ram1_we) ram[ram1_addr] <= ram1_din;
      else         ram1_dout <= ram[ram1_addr];
    end
  end

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // behavioural model state
  logic [W-1:0] mem [D];
  bit           m_init;
  int           m_ptr, m_rr;
  logic [N-1:0] m_rsp_v;
  logic [W-1:0] m_rsp_d [N];

  bit           n_init;
  int           n_ptr, n_rr;
  logic [N-1:0] n_rsp_v;
  logic [W-1:0] n_rsp_d [N];
  logic [1:0]   n_wr_en;
  int           n_wr_a [2];
  logic [W-1:0] n_wr_d [2];

  int c_order [$];

  initial for (int k = 0; k < D; k++) mem[k] = '0;

  function automatic logic [AW-1:0] addr_of(input int i);
    return req_addr[i*AW +: AW];
  endfunction

  function automatic logic [W-1:0] wd_of(input int i);
    return req_wdata[i*W +: W];
  endfunction

  task automatic model_step();
    logic [PT-1:0]  e0, e1;
    logic [N-1:0]   er;
    logic [N*W-1:0] ed;
    int ga, gb, b, g;
    e0 = '0;
    e1 = '0;
    er = '0;
    ed = '0;
    n_rsp_v = '0;
    n_wr_en = '0;
    for (int k = 0; k < N; k++) n_rsp_d[k] = '0;
    n_init = m_init;
    n_ptr  = m_ptr;
    n_rr   = m_rr;
    if (m_init) begin
      e0 = {2'b11, AW'(m_ptr), W'(0)};
      e1 = {2'b11, AW'(m_ptr + 1), W'(0)};
      n_wr_en = 2'b11;
      n_wr_a[0] = m_ptr;
      n_wr_a[1] = m_ptr + 1;
      n_wr_d[0] = '0;
      n_wr_d[1] = '0;
      if (clear) n_ptr = 0;
      else if (m_ptr == D - 2) n_init = 0;
      else n_ptr = m_ptr + 2;
    end else begin
      c_order.delete();
      for (int k = 0; k < N; k++)
        if (req_valid[(m_rr + k) % N]) c_order.push_back((m_rr + k) % N);
      ga = -1;
      gb = -1;
      if (c_order.size() > 0) ga = c_order[0];
      if (c_order.size() > 1) begin
        b = c_order[1];
        if (!(addr_of(b) == addr_of(ga) && (req_we[ga] || req_we[b])))
          gb = b;
      end
      for (int p = 0; p < 2; p++) begin
        g = (p == 0) ? ga : gb;
        if (g >= 0) begin
          er[g] = 1'b1;
          if (p == 0) e0 = {1'b1, req_we[g], addr_of(g), wd_of(g)};
          else        e1 = {1'b1, req_we[g], addr_of(g), wd_of(g)};
          if (req_we[g]) begin
            n_wr_en[p] = 1'b1;
            n_wr_a[p]  = int'(addr_of(g));
            n_wr_d[p]  = wd_of(g);
          end else begin
            n_rsp_v[g] = 1'b1;
            n_rsp_d[g] = mem[addr_of(g)];
          end
        end
      end
      if (gb >= 0)      n_rr = (gb + 1) % N;
      else if (ga >= 0) n_rr = (ga + 1) % N;
      if (clear) begin
        n_init = 1;
        n_ptr  = 0;
      end
    end
    for (int k = 0; k < N; k++)
      if (m_rsp_v[k]) ed[k*W +: W] = m_rsp_d[k];
    chk("busy", init_busy, m_init);
    chk("ready", req_ready, er);
    chk("port0", {ram0_en, ram0_we, ram0_addr, ram0_din}, e0);
    chk("port1", {ram1_en, ram1_we, ram1_addr, ram1_din}, e1);
    chk("rsp_valid", rsp_valid, m_rsp_v);
    chk("rsp_rdata", rsp_rdata, ed);
  endtask

  // compare process: every falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_busy", init_busy, 1);
        chk("rst_ready", req_ready, 0);
        chk("rst_ram", {ram0_en, ram0_we, ram1_en, ram1_we}, 0);
        chk("rst_rsp", rsp_valid, 0);
        n_init  = 1;
        n_ptr   = 0;
        n_rr    = 0;
        n_rsp_v = '0;
        n_wr_en = '0;
      end else begin
        model_step();
      end
    end
  end

  // model commit at the rising edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_init  <= 1'b1;
      m_ptr   <= 0;
      m_rr    <= 0;
      m_rsp_v <= '0;
    end else begin
      m_init  <= n_init;
      m_ptr   <= n_ptr;
      m_rr    <= n_rr;
      m_rsp_v <= n_rsp_v;
      for (int k = 0; k < N; k++) m_rsp_d[k] <= n_rsp_d[k];
      for (int p = 0; p < 2; p++)
        if (n_wr_en[p]) mem[n_wr_a[p]] <= n_wr_d[p];
    end
  end

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0;
    req_we    = '0;
  endtask

  task automatic set(input int i, input bit we, input int a,
                     input logic [W-1:0] d);
    req_valid[i]        = 1'b1;
    req_we[i]           = we;
    req_addr[i*AW +: AW] = AW'(a);
    req_wdata[i*W +: W]  = d;
  endtask

  task automatic count_init(input int base, output int cyc);
    cyc = base;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!init_busy) break;
      if (cyc == 0)
        chk("sweep_first", {ram0_addr, ram1_addr}, {5'd0, 5'd1});
      if (cyc == 15)
        chk("sweep_last", {ram0_addr, ram1_addr}, {5'd30, 5'd31});
      cyc++;
    end
  endtask

  int  cnt;
  bit  found;

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    count_init(0, cnt);
    chk("t1_init_cycles", cnt, 16);

    cyc_start(); idle(); set(0, 1, 5, 32'hA5A5_0001);
    @(negedge clk); chk("t2_wr_ready", req_ready, 4'b0001);
    cyc_start(); idle(); set(1, 0, 5, 0);
    @(negedge clk); chk("t2_rd_ready", req_ready, 4'b0010);
    cyc_start(); idle();
    @(negedge clk);
    chk("t2_rsp_valid", rsp_valid, 4'b0010);
    chk("t2_rsp_data", rsp_rdata[W +: W], 32'hA5A5_0001);

    cyc_start(); idle(); set(3, 0, 9, 0);
    @(negedge clk); chk("t3_park", req_ready, 4'b1000);
    for (int c = 0; c < 3; c++) begin
      cyc_start(); idle();
      for (int i = 0; i < N; i++) set(i, 0, 10 + i, 0);
      @(negedge clk);
      chk("t3_grant", req_ready, (c % 2 == 0) ? 4'b0011 : 4'b1100);
      if (c > 0)
        chk("t3_rsp", rsp_valid, (c % 2 == 1) ? 4'b0011 : 4'b1100);
    end
    cyc_start(); idle();
    @(negedge clk); chk("t3_rsp_last", rsp_valid, 4'b0011);

    cyc_start(); idle(); set(0, 0, 20, 0);
    @(negedge clk); chk("t4_prep", req_ready, 4'b0001);
    cyc_start(); idle(); set(1, 1, 7, 32'h1234_5678); set(2, 0, 7, 0);
    @(negedge clk); chk("t4_conflict", req_ready, 4'b0010);
    cyc_start(); idle(); set(2, 0, 7, 0);
    @(negedge clk); chk("t4_pending", req_ready, 4'b0100);
    cyc_start(); idle(); set(1, 0, 7, 0); set(2, 0, 7, 0);
    @(negedge clk);
    chk("t4_rd_new_v", rsp_valid, 4'b0100);
    chk("t4_rd_new_d", rsp_rdata[2*W +: W], 32'h1234_5678);
    chk("t4_rdrd", req_ready, 4'b0110);

    cyc_start(); idle(); set(3, 0, 7, 0); clear = 1'b1;
    @(negedge clk);
    chk("t4_rdrd_rsp", rsp_valid, 4'b0110);
    chk("t5_clear_grant", req_ready, 4'b1000);
    chk("t5_clear_busy", init_busy, 0);
    cyc_start(); idle(); clear = 1'b0;
    @(negedge clk);
    chk("t5_rsp_kept", rsp_valid, 4'b1000);
    chk("t5_rsp_data", rsp_rdata[3*W +: W], 32'h1234_5678);
    chk("t5_busy", init_busy, 1);
    count_init(1, cnt);
    chk("t5_init_cycles", cnt, 16);
    cyc_start(); idle(); set(0, 0, 7, 0);
    @(negedge clk); chk("t5_rd_ready", req_ready, 4'b0001);
    cyc_start(); idle();
    @(negedge clk);
    chk("t5_rd_valid", rsp_valid, 4'b0001);
    chk("t5_rd_zero", rsp_rdata[0 +: W], 0);

    cyc_start(); idle(); set(2, 0, 3, 0);
    @(posedge clk); #1; idle();
    #1 chk("t7_rsp_before", rsp_valid, 4'b0100);
    rst_n = 1'b0;
    #1 chk("t7_rsp_cancel", rsp_valid, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    count_init(0, cnt);
    chk("t7_init_cycles", cnt, 16);

    cyc_start(); idle(); clear = 1'b1;
    @(negedge clk);
    cyc_start(); clear = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (init_busy && ram0_addr == 5'd10) found = 1'b1;
    end
    chk("t6_reach_ptr10", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_busy", init_busy, 1);
    chk("t6_async_ram", {ram0_en, ram0_we, ram1_en, ram1_we}, 0);
    chk("t6_async_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_restart", {ram0_en, ram0_addr, ram1_addr}, {1'b1, 5'd0, 5'd1});
    count_init(1, cnt);
    chk("t6_init_cycles", cnt, 16);

    for (int c = 0; c < 400; c++) begin
      cyc_start(); idle();
      clear = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) != 0)
          set(i, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom);
    end
    cyc_start(); idle(); clear = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
